// File: rtl/axi_fifo_pkt.sv
// AXI-Stream FIFO on a single block RAM with a two-stage read pipeline.
// Optional store-and-forward mode releases words only once their packet is committed.
module axi_fifo_pkt #(
   parameter int DATA_WIDTH          = 32,
   parameter int TUSER_WIDTH         = 1,
   parameter int ADDR_WIDTH          = 8,
   parameter int ALMOST_FULL_THRESH  = 16,
   parameter int ALMOST_EMPTY_THRESH = 4,
   parameter int PACKET_MODE         = 0
) (
   input  logic                   clk,
   input  logic                   sync_reset_n,
   input  logic                   s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic                   s_axis_tlast,
   output logic                   s_axis_tready,
   output logic                   m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]  m_axis_tdata,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                   m_axis_tlast,
   input  logic                   m_axis_tready,
   output logic [ADDR_WIDTH+1:0]  data_count,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [ADDR_WIDTH:0]    pkt_count,
   output logic                   overflow_commit
);

   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int WORD_W = DATA_WIDTH + TUSER_WIDTH + 1;
   localparam int CNT_W  = ADDR_WIDTH + 2;
   localparam int PTR_W  = ADDR_WIDTH + 1;
   localparam bit PKT    = (PACKET_MODE != 0);

   localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - ALMOST_FULL_THRESH);
   localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(ALMOST_EMPTY_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] ram_q;
   logic [WORD_W-1:0] out_word;
   logic              ram_q_valid;
   logic              out_valid;

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  commit_ptr;
   logic [PTR_W-1:0]  vis_ptr;

   logic full, empty, wr_en, rd_en, out_ready, stage_move, out_take;
   logic tlast_commit, force_commit, pkt_inc, pkt_dec;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      vis_ptr      = PKT ? commit_ptr : wr_ptr;
      full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
      empty        = (rd_ptr == vis_ptr);
      wr_en        = s_axis_tvalid && !full;
      out_ready    = !out_valid || m_axis_tready;
      out_take     = out_valid && m_axis_tready;
      stage_move   = ram_q_valid && out_ready;
      rd_en        = !empty && !(ram_q_valid && out_valid && !m_axis_tready);
      tlast_commit = PKT && wr_en && s_axis_tlast;
      // RAM holds only an unfinished packet: release it so the writer is not deadlocked.
      force_commit = PKT && full && (commit_ptr == rd_ptr);
      pkt_inc      = tlast_commit || force_commit;
      pkt_dec      = PKT && out_take && m_axis_tlast;
   end

   // Ready comes from registered pointers only, so a read frees a slot one cycle later.
   assign s_axis_tready = !full;
   assign m_axis_tvalid = out_valid;
   assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = out_word;

   // NOTE: the RAM array and its read register carry no reset so they map onto block RAM;
   // the pointers and valid flags are what define the FIFO content.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
      if (rd_en) ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         commit_ptr      <= '0;
         ram_q_valid     <= 1'b0;
         out_valid       <= 1'b0;
         out_word        <= '0;
         data_count      <= '0;
         pkt_count       <= '0;
         almost_full     <= 1'b0;
         almost_empty    <= 1'b1;
         overflow_commit <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;

         if (tlast_commit)      commit_ptr <= wr_ptr + PTR_ONE;
         else if (force_commit) commit_ptr <= wr_ptr;
         overflow_commit <= force_commit;

         if (rd_en)           ram_q_valid <= 1'b1;
         else if (stage_move) ram_q_valid <= 1'b0;

         if (stage_move) begin
            out_valid <= 1'b1;
            out_word  <= ram_q;
         end else if (out_take) begin
            out_valid <= 1'b0;
         end

         unique case ({wr_en, out_take})
            2'b10:   data_count <= data_count + CNT_ONE;
            2'b01:   data_count <= data_count - CNT_ONE;
            default: data_count <= data_count;
         endcase

         unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_count <= pkt_count + PTR_ONE;
            2'b01:   pkt_count <= pkt_count - PTR_ONE;
            default: pkt_count <= pkt_count;
         endcase

         // Flags follow data_count one cycle behind.
         almost_full  <= (data_count >= AF_LEVEL);
         almost_empty <= (data_count <= AE_LEVEL);
      end
   end

endmodule
